// File: rtl/seq_det_pkg.sv
// Shared types for the serial pattern detector.
// Control state encoding and overlap mode constants.
package seq_det_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } state_e;

    localparam logic MODE_OVL  = 1'b1;
    localparam logic MODE_NOVL = 1'b0;

endpackage

// File: rtl/seq_det_shreg.sv
// History shift register with saturating fill counter.
// Exposes the post-edge view so the top can compare before the edge.
module seq_det_shreg #(
    parameter int W = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_shift,
    input  logic                     i_bit,
    input  logic                     i_clr,
    input  logic                     i_drop,
    output logic [W-1:0]             o_hist_nxt,
    output logic [$clog2(W+1)-1:0]   o_fill_nxt
);

    localparam int FW = $clog2(W + 1);
    localparam logic [FW-1:0] FULL = FW'(W);

    logic [W-1:0]  r_hist;
    logic [FW-1:0] r_fill;

    // Next history and fill count as seen just after this edge
    always_comb begin
        o_hist_nxt = r_hist;
        o_fill_nxt = r_fill;
        if (i_clr) begin
            o_hist_nxt = '0;
            o_fill_nxt = '0;
        end else if (i_shift) begin
            o_hist_nxt = {r_hist[W-2:0], i_bit};
            o_fill_nxt = (r_fill == FULL) ? FULL : r_fill + 1'b1;
        end
    end

    // Commit history; a dropped fill restarts the fresh-bit count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hist <= '0;
            r_fill <= '0;
        end else begin
            r_hist <= o_hist_nxt;
            r_fill <= i_drop ? '0 : o_fill_nxt;
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Serial pattern detector with runtime pattern/mode and match counter.
// Registered match pulse; config writes win over concurrent data.
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int                PAT_W   = 3,
    parameter logic [PAT_W-1:0]  PATTERN = 3'b010,
    parameter logic              OVERLAP = 1'b1,
    parameter int                CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             cfg_we,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic             cnt_sat
);

    localparam int FW = $clog2(PAT_W + 1);
    localparam logic [FW-1:0] FULL = FW'(PAT_W);
    localparam logic [CNT_W-1:0] CMAX = '1;

    logic [PAT_W-1:0] r_pat;
    logic             r_mode;
    state_e           r_state;
    logic             r_match;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;

    logic             w_accept;
    logic [PAT_W-1:0] w_hist_nxt;
    logic [FW-1:0]    w_fill_nxt;
    logic             w_full;
    logic             w_eval;
    logic             w_hit;
    logic             w_drop;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;

    assign w_accept = in_valid & ~cfg_we;
    assign w_full   = (w_fill_nxt == FULL);
    assign w_eval   = (r_state == ARMED) | w_full;
    assign w_hit    = w_accept & w_eval & w_full
                    & (w_hist_nxt == r_pat);
    assign w_drop   = w_hit & (r_mode == MODE_NOVL);

    seq_det_shreg #(
        .W (PAT_W)
    ) u_shreg (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_shift    (w_accept),
        .i_bit      (in_bit),
        .i_clr      (cfg_we),
        .i_drop     (w_drop),
        .o_hist_nxt (w_hist_nxt),
        .o_fill_nxt (w_fill_nxt)
    );

    // Control state: armed once a full window of fresh bits is held
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            FILL: begin
                if (w_accept && w_full && !w_drop)
                    w_state_nxt = ARMED;
            end
            ARMED: begin
                if (cfg_we || w_drop)
                    w_state_nxt = FILL;
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Next counter value; clear beats a coincident hit
    always_comb begin
        w_cnt_nxt = r_cnt;
        if (cnt_clr)
            w_cnt_nxt = '0;
        else if (w_hit && (r_cnt != CMAX))
            w_cnt_nxt = r_cnt + 1'b1;
    end

    // Pattern and mode registers, reloaded by config writes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pat  <= PATTERN;
            r_mode <= OVERLAP;
        end else if (cfg_we) begin
            r_pat  <= cfg_pattern;
            r_mode <= cfg_overlap;
        end
    end

    // FSM state, match pulse, counter and saturation flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= FILL;
            r_match <= 1'b0;
            r_cnt   <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_match <= w_hit;
            r_cnt   <= w_cnt_nxt;
            r_sat   <= (w_cnt_nxt == CMAX);
        end
    end

    assign match       = r_match;
    assign match_count = r_cnt;
    assign cnt_sat     = r_sat;

endmodule
